// File: rtl/regfile_writeback.sv
// regfile_writeback: register bank with one commit per cycle, PC-stage priority and a 2-entry ALU write FIFO
module regfile_writeback #(
  parameter int NUM_REGS = 64,
  parameter logic [7:0] SWITCH_ADDR = 8'd36
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PRG_write_flag,
  input  logic [7:0]  PRG_write_addr,
  input  logic [31:0] PRG_write_data,
  input  logic        alu_we,
  input  logic [7:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic [7:0]  rd_addr_a,
  input  logic [7:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic        rd_pend_a,
  output logic        rd_pend_b,
  output logic        switch_mode,
  output logic        wr_overflow,
  output logic        wr_bad_addr
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [8:0] LIM = 9'(NUM_REGS);
  logic [31:0] regs [NUM_REGS];
  logic [7:0]  fa [2];
  logic [31:0] fd [2];
  logic [1:0]  cnt;
  logic        hd, tl, pop, push, drop, wv;
  logic [7:0]  wa;
  logic [31:0] wd;

  function automatic logic [31:0] rd(input logic [7:0] a);
    return ({1'b0, a} < LIM) ? regs[a[AW-1:0]] : '0;
  endfunction

  function automatic logic pend(input logic [7:0] a);
    return (a != 8'd0) && ((cnt == 2'd2 && (fa[0] == a || fa[1] == a)) || (cnt == 2'd1 && fa[hd] == a));
  endfunction

  // arbitration: PC stage first, then FIFO head, then a direct ALU write; a full FIFO with no pop drops the ALU write
  always_comb begin
    pop = !PRG_write_flag && cnt != 2'd0;
    drop = alu_we && cnt == 2'd2 && !pop;
    push = alu_we && (PRG_write_flag || cnt != 2'd0) && !drop;
    wv = PRG_write_flag || cnt != 2'd0 || alu_we;
    wa = PRG_write_flag ? PRG_write_addr : pop ? fa[hd] : alu_addr;
    wd = PRG_write_flag ? PRG_write_data : pop ? fd[hd] : alu_data;
  end

  assign alu_stall = cnt == 2'd2;
  assign rd_data_a = rd(rd_addr_a);
  assign rd_data_b = rd(rd_addr_b);
  assign rd_pend_a = pend(rd_addr_a);
  assign rd_pend_b = pend(rd_addr_b);

  // commit the arbitrated write, maintain FIFO pointers and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      cnt <= '0;
      hd <= 1'b0;
      tl <= 1'b0;
      switch_mode <= 1'b0;
      wr_overflow <= 1'b0;
      wr_bad_addr <= 1'b0;
    end else begin
      if (wv && {1'b0, wa} >= LIM) wr_bad_addr <= 1'b1;
      else if (wv && wa != 8'd0) regs[wa[AW-1:0]] <= wd;
      if (wv && wa == SWITCH_ADDR) switch_mode <= wd[0];
      if (drop) wr_overflow <= 1'b1;
      if (pop) hd <= ~hd;
      if (push) begin
        fa[tl] <= alu_addr;
        fd[tl] <= alu_data;
        tl <= ~tl;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed plan plus randomized traffic against a queue-based model
module tb_regfile_writeback;
  logic clock = 0, rst = 1;
  logic prg_f = 0, we = 0;
  logic [7:0] prg_a = 0, aa = 0, ra = 0, rb = 0;
  logic [31:0] prg_d = 0, ad = 0;
  logic stall, pa, pb, sw, ovf, bad_addr;
  logic [31:0] da, db;
  int total = 0, bad = 0;
  bit chk_en = 0;

  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  wr_t h;
  logic [31:0] m [64];
  bit msw = 0, movf = 0, mbad = 0;
  logic [7:0] pool [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd36, 8'd63, 8'd64, 8'd200};

  regfile_writeback dut (
    .clock(clock), .reset(rst),
    .PRG_write_flag(prg_f), .PRG_write_addr(prg_a), .PRG_write_data(prg_d),
    .alu_we(we), .alu_addr(aa), .alu_data(ad), .alu_stall(stall),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(da), .rd_data_b(db),
    .rd_pend_a(pa), .rd_pend_b(pb), .switch_mode(sw),
    .wr_overflow(ovf), .wr_bad_addr(bad_addr)
  );

  always #5 clock = ~clock;

  function automatic void commit(input logic [7:0] a, input logic [31:0] d);
    if (a >= 64) mbad = 1;
    else if (a != 0) m[a[5:0]] = d;
    if (a == 36) msw = d[0];
  endfunction

  function automatic logic [31:0] rexp(input logic [7:0] a);
    return (a < 64) ? m[a[5:0]] : 32'd0;
  endfunction

  function automatic logic pexp(input logic [7:0] a);
    foreach (q[i]) if (a != 0 && q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    if (rst) begin
      foreach (m[i]) m[i] = 0;
      q.delete();
      msw = 0;
      movf = 0;
      mbad = 0;
    end else if (prg_f) begin
      commit(prg_a, prg_d);
      if (we) begin
        if (q.size() < 2) q.push_back('{aa, ad});
        else movf = 1;
      end
    end else if (q.size() > 0) begin
      h = q.pop_front();
      commit(h.a, h.d);
      if (we) q.push_back('{aa, ad});
    end else if (we) commit(aa, ad);
  end

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    #1;
    if (chk_en) begin
      cmp("m_rd_a", da, rexp(ra));
      cmp("m_rd_b", db, rexp(rb));
      cmp("m_pend_a", 32'(pa), 32'(pexp(ra)));
      cmp("m_pend_b", 32'(pb), 32'(pexp(rb)));
      cmp("m_stall", 32'(stall), 32'(q.size() == 2));
      cmp("m_switch", 32'(sw), 32'(msw));
      cmp("m_ovf", 32'(ovf), 32'(movf));
      cmp("m_bad", 32'(bad_addr), 32'(mbad));
    end
  end

  task automatic nxt;
    @(negedge clock);
    #2;
  endtask

  task automatic set_in(input bit pf, input logic [7:0] p_a, input logic [31:0] p_d,
                        input bit w, input logic [7:0] a, input logic [31:0] d);
    prg_f = pf; prg_a = p_a; prg_d = p_d; we = w; aa = a; ad = d;
  endtask

  initial begin
    nxt;
    rst = 0;
    chk_en = 1;
    #1;
    cmp("rst_stall", 32'(stall), 0);
    cmp("rst_switch", 32'(sw), 0);
    cmp("rst_ovf", 32'(ovf), 0);
    cmp("rst_bad", 32'(bad_addr), 0);
    cmp("rst_rd", da, 0);
    set_in(0, 0, 0, 1, 5, 32'hDEADBEEF); ra = 5;
    nxt; set_in(0, 0, 0, 0, 0, 0); #1;
    cmp("direct_rd", da, 32'hDEADBEEF);
    cmp("direct_pend", 32'(pa), 0);
    cmp("direct_stall", 32'(stall), 0);
    set_in(1, 7, 32'h11, 1, 9, 32'h22); ra = 7; rb = 9;
    nxt; set_in(0, 0, 0, 0, 0, 0); #1;
    cmp("coll_prg", da, 32'h11);
    cmp("coll_alu_old", db, 0);
    cmp("coll_pend", 32'(pb), 1);
    nxt;
    cmp("coll_alu_new", db, 32'h22);
    cmp("coll_pend_clr", 32'(pb), 0);
    set_in(1, 40, 1, 1, 1, 32'hA1);
    nxt; set_in(1, 41, 2, 1, 2, 32'hA2);
    nxt; #1; cmp("fill_stall", 32'(stall), 1);
    set_in(1, 42, 3, 1, 3, 32'hA3);
    nxt; #1; cmp("fill_ovf", 32'(ovf), 1);
    set_in(1, 43, 4, 0, 0, 0);
    nxt; set_in(0, 0, 0, 0, 0, 0); ra = 1; rb = 2; #1;
    cmp("fill_r1_wait", da, 0);
    nxt; cmp("fill_r1", da, 32'hA1); cmp("fill_r2_wait", db, 0);
    nxt; cmp("fill_r2", db, 32'hA2);
    ra = 3; #1; cmp("fill_r3_dropped", da, 0);
    set_in(1, 36, 1, 0, 0, 0);
    nxt; set_in(1, 36, 0, 0, 0, 0); #1; cmp("switch_on", 32'(sw), 1);
    nxt; set_in(0, 0, 0, 1, 0, 32'hFF); #1; cmp("switch_off", 32'(sw), 0);
    nxt; set_in(1, 200, 32'h5A, 0, 0, 0); ra = 0; #1; cmp("zero_rd", da, 0);
    nxt; set_in(0, 0, 0, 0, 0, 0); #1; cmp("bad_addr", 32'(bad_addr), 1);
    set_in(1, 50, 0, 1, 10, 32'h10);
    nxt; set_in(1, 50, 0, 1, 11, 32'h11);
    nxt; #1; cmp("mid_stall", 32'(stall), 1);
    set_in(0, 0, 0, 0, 0, 0); rst = 1;
    nxt; rst = 0; ra = 10; rb = 11; #1;
    cmp("mid_stall_clr", 32'(stall), 0);
    cmp("mid_rd", da, 0);
    cmp("mid_pend", 32'(pa), 0);
    cmp("mid_ovf_clr", 32'(ovf), 0);
    cmp("mid_r36", {31'd0, sw}, 0);
    nxt; nxt;
    cmp("mid_no_commit_a", da, 0);
    cmp("mid_no_commit_b", db, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      prg_f = $urandom_range(0, 2) == 0;
      prg_a = pool[$urandom_range(0, 9)];
      prg_d = $urandom;
      we = $urandom_range(0, 1) == 1 && (!stall || $urandom_range(0, 7) == 0);
      aa = pool[$urandom_range(0, 9)];
      ad = $urandom;
      ra = pool[$urandom_range(0, 9)];
      rb = pool[$urandom_range(0, 9)];
      nxt;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Register bank with a single-port write arbiter, sitting directly downstream of the program-counter stage. It accepts register writes from the PC stage (POP, GSA and SWITCH results on `PRG_write_*`) and from the ALU. It commits at most one write per clock and buffers colliding ALU writes in a 2-entry FIFO. It serves two asynchronous read ports and exports the switch register bit to the rest of the core.

## Interface
- `NUM_REGS`, 64: number of implemented 32-bit registers. Addresses ≥ `NUM_REGS` are unimplemented.
- `SWITCH_ADDR`, 8'd36: register whose bit 0 drives `switch_mode`.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high. Sampled on the rising edge of `clock`.
- `PRG_write_flag` in 1: PC-stage write valid. This is a level, sampled every rising edge.
- `PRG_write_addr` in 8: PC-stage destination register.
- `PRG_write_data` in 32: PC-stage write data.
- `alu_we` in 1: ALU write valid.
- `alu_addr` in 8: ALU destination register.
- `alu_data` in 32: ALU write data.
- `alu_stall` out 1: FIFO full. The ALU must hold off.
- `rd_addr_a`, `rd_addr_b` in 8: read addresses.
- `rd_data_a`, `rd_data_b` out 32: committed register contents.
- `rd_pend_a`, `rd_pend_b` out 1: read address matches a valid FIFO entry, so the read value is stale.
- `switch_mode` out 1: bit 0 of register `SWITCH_ADDR`.
- `wr_overflow` out 1: sticky. Set when an ALU write is dropped.
- `wr_bad_addr` out 1: sticky. Set when any committed write targets an unimplemented address.

## Operation
- **Storage:** `NUM_REGS`×32 registers.
  - Register 0 reads as 0 always; writes to it are discarded silently.
  - Unimplemented addresses read as 0.
- **Write arbitration:** exactly one commit per cycle, in strict priority order:
  1. PC-stage write, if `PRG_write_flag`.
  2. Otherwise the FIFO head, if the FIFO is non-empty (head is then popped).
  3. Otherwise the ALU write directly, if `alu_we` and the FIFO is empty.
- **ALU write that does not commit directly:** pushed to the FIFO tail. This happens when `PRG_write_flag` is high or the FIFO is non-empty.
- **Simultaneous pop and push:** allowed in the same cycle. The count is unchanged and order is preserved.
- **Overflow:** if the FIFO is full, no pop occurs that cycle, and `alu_we` is high, the ALU write is dropped and `wr_overflow` is set.
- **Write ordering:** writes to the same address commit in arrival order within each source. A PC-stage write overtakes older buffered ALU writes. This is intended: the PC stage only issues writes after the ALU result for that instruction has retired.
- **Counting:** FIFO count is 2 bits (0..2). Head and tail pointers are 1 bit and wrap modulo 2.
- **Outputs:**
  - `alu_stall` = (count == 2).
  - `rd_pend_x` = OR over valid FIFO entries of (entry addr == `rd_addr_x`). Register 0 never flags.
  - `switch_mode` is registered; it follows register `SWITCH_ADDR` bit 0 after commit.
  - The PC stage's SWITCH op writes `result[0]` zero-extended to address 36.
- **Reset:**
  - All registers cleared; FIFO emptied (count = 0, pointers = 0).
  - `switch_mode`, `wr_overflow` and `wr_bad_addr` cleared.
  - Inputs are ignored in the reset cycle. Reset mid-operation discards buffered writes.

## Timing
- **Write latency:** a write committed at rising edge N is visible on `rd_data_*` immediately after edge N.
- **No bypass:** a read in the same cycle as a write to the same address returns the old value.
- **Buffered ALU writes:** minimum latency is 2 edges (pushed at N, earliest commit at N+1).
- **Stall:** `alu_stall` is registered-state derived and combinational from count. The ALU samples it before driving `alu_we` in the same cycle.
- **Setup:** the PC stage updates `PRG_write_*` on the falling edge, so the inputs are stable for the rising-edge sample.
- **Read ports:** `rd_data_*` and `rd_pend_*` are combinational from the addresses and current state.
- **Reset values:** `alu_stall`=0, `switch_mode`=0, `wr_overflow`=0, `wr_bad_addr`=0. `rd_data_*`=0 for any address.

## Test plan
- **Reset, then direct ALU write:** `alu_we` with addr 5, data 0xDEADBEEF; no PRG write. → After 1 edge `rd_data_a`(5) = 0xDEADBEEF; `rd_pend_a`=0; `alu_stall`=0.
- **Collision:** `PRG_write_flag` with addr 7, data 0x11, together with ALU addr 9, data 0x22. → Edge 1: reg7=0x11, reg9 unchanged, `rd_pend_b`(9)=1. Edge 2: reg9=0x22, pend=0.
- **Fill and overflow:** hold `PRG_write_flag` for 4 cycles while the ALU writes addresses 1, 2, 3 in successive cycles. → `alu_stall`=1 after the 2nd push; 3rd write dropped, `wr_overflow`=1. After PRG releases, reg1 then reg2 commit in order; reg3 stays 0.
- **SWITCH:** PRG write addr 36, data 0x1. → `switch_mode`=1 after the edge. Write 0x0 → `switch_mode`=0.
- **Bad and zero addresses:** ALU write addr 0, data 0xFF. → `rd_data`(0)=0. PRG write addr 200 → `wr_bad_addr`=1 and no register changes.
- **Reset mid-operation:** FIFO count 2, assert `reset` for 1 cycle. → Count 0, `alu_stall`=0, all regs 0, buffered writes never commit.
